// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result handshake bundle for nibble_serial_add_ctrl.
// The sub signal exists only when NIBBLE_ADD_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin,
`ifdef NIBBLE_ADD_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder sequencer that feeds one external 4-bit adder a nibble per cycle, LSB first.
// Optional subtract mode enabled with `define NIBBLE_ADD_SUB_EN.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  nibble_serial_add_ctrl_if.slave bus,
  output logic [3:0]              fa_a,
  output logic [3:0]              fa_b,
  output logic                    fa_cin,
  input  logic [3:0]              fa_sum,
  input  logic                    fa_cout
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             carry, cout_r, sub_op, last;
  logic [CW-1:0]    cnt;

`ifdef NIBBLE_ADD_SUB_EN
  assign sub_op = bus.sub;
`else
  assign sub_op = 1'b0;
`endif

  assign last = (cnt == CW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    fa_a          = 4'h0;
    fa_b          = 4'h0;
    fa_cin        = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        fa_a   = a_sh[3:0];
        fa_b   = b_sh[3:0];
        fa_cin = carry;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        // Result handshake only; a pending request waits for IDLE.
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sh  <= bus.a;
          b_sh  <= sub_op ? ~bus.b : bus.b;
          carry <= sub_op ? 1'b1 : bus.cin;
          cnt   <= '0;
        end
        RUN: begin
          // Each adder nibble enters at the top; after NIB steps nibble 0 sits at the bottom.
          res   <= (res >> 4) | (WIDTH'(fa_sum) << (WIDTH - 4));
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (last) cout_r <= fa_cout;
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = res;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural 4-bit adder beside it.
// Subtract vectors run only when NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fa_a, fa_b, fa_sum;
  logic       fa_cin, fa_cout;
  logic       sub_v = 1'b0;
  int         checks = 0;
  int         errors = 0;

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_cin (fa_cin),
    .fa_sum (fa_sum),
    .fa_cout(fa_cout)
  );

  // Stand-in for the external combinational 4-bit full adder.
  assign {fa_cout, fa_sum} = {1'b0, fa_a} + {1'b0, fa_b} + {4'b0, fa_cin};

`ifdef NIBBLE_ADD_SUB_EN
  assign bus.sub = sub_v;
`endif

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one request, scramble the operand bus, then wait for out_valid.
  // lat counts edges from the accept edge (inclusive); -1 on timeout.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input logic sv, output int lat);
    bus.a = av; bus.b = bv; bus.cin = cv; sub_v = sv; bus.in_valid = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      bus.in_valid = 1'b0;
      bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = ~cv; sub_v = ~sv;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: sum=%h cout=%b, want 0000 0", bus.sum, bus.cout);
    end
    checks++;
    if (fa_a !== 4'h0 || fa_b !== 4'h0 || fa_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_fa: fa_a=%h fa_b=%h fa_cin=%b, want 0 0 0", fa_a, fa_b, fa_cin);
    end
  endtask

  task automatic test_basic_add();
    int lat;
    bus.out_ready = 1'b1;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, want 5", lat);
    end
    checks++;
    if (bus.sum !== 16'h5555 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: sum=%h cout=%b, want 5555 0", bus.sum, bus.cout);
    end
    step();
  endtask

  task automatic test_carry_ripple();
    int runs = 0;
    int bad  = 0;
    bus.out_ready = 1'b1;
    bus.a = 16'hFFFF; bus.b = 16'h0000; bus.cin = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) begin
      runs++;
      if (fa_cin !== 1'b1) bad++;
      step();
    end
    checks++;
    if (runs !== 4 || bad !== 0) begin
      errors++;
      $display("FAIL ripple_fa_cin: run_cycles=%0d low_cin=%0d, want 4 0", runs, bad);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL ripple_sum: valid=%b sum=%h cout=%b, want 1 0000 1",
               bus.out_valid, bus.sum, bus.cout);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    bus.out_ready = 1'b0;
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 5 || bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL bp_sum: lat=%0d sum=%h cout=%b, want 5 0000 1", lat, bus.sum, bus.cout);
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0000 || bus.cout !== 1'b1 ||
          bus.in_ready !== 1'b0) bad++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int rises = 0;
    bus.out_ready = 1'b1;
    bus.a = 16'h00FF; bus.b = 16'h0001; bus.cin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || fa_a !== 4'h0 || fa_cin !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: in_ready=%b out_valid=%b fa_a=%h fa_cin=%b, want 1 0 0 0",
               bus.in_ready, bus.out_valid, fa_a, fa_cin);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.out_valid !== 1'b0) rises++;
    end
    checks++;
    if (rises !== 0) begin
      errors++;
      $display("FAIL midrst_novalid: out_valid high %0d cycles, want 0", rises);
    end
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 5 || bus.sum !== 16'h0007 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next: lat=%0d sum=%h cout=%b, want 5 0007 0", lat, bus.sum, bus.cout);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int gap = -1;
    int seen_sum = -1;
    bus.out_ready = 1'b1;
    bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0; bus.in_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.out_valid) seen_sum = int'(bus.sum);
      if (bus.in_ready) begin
        gap = i;
        break;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (gap !== 6) begin
      errors++;
      $display("FAIL b2b_gap: accept-to-ready %0d edges, want 6", gap);
    end
    checks++;
    if (seen_sum !== 3) begin
      errors++;
      $display("FAIL b2b_sum: sum=%0d, want 3", seen_sum);
    end
    step();
  endtask

`ifdef NIBBLE_ADD_SUB_EN
  task automatic test_sub();
    int lat;
    bus.out_ready = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 5 || bus.sum !== 16'hFFFE || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: lat=%0d sum=%h cout=%b, want 5 fffe 0", lat, bus.sum, bus.cout);
    end
    step();
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 5 || bus.sum !== 16'h0002 || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: lat=%0d sum=%h cout=%b, want 5 0002 1", lat, bus.sum, bus.cout);
    end
    step();
    run_op(16'h0010, 16'h0001, 1'b1, 1'b0, lat);
    checks++;
    if (bus.sum !== 16'h0012 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_off_add: sum=%h cout=%b, want 0012 0", bus.sum, bus.cout);
    end
    step();
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef NIBBLE_ADD_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs WIDTH-bit additions by time-sharing one external combinational 4-bit adder (the NOR-gate 4-bit full adder), one nibble per cycle, least significant nibble first.
- Owns the operand shift registers, the inter-nibble carry register and the result assembly.
- Sits between a valid/ready request source and a valid/ready result sink; the adder is instantiated beside it, driven by the fa_* ports.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, derived as WIDTH/4 (localparam, not overridable), number of nibble steps per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- a  input  WIDTH  operand A; sampled on accept.
- b  input  WIDTH  operand B; sampled on accept.
- cin  input  1  carry into nibble 0; sampled on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- sum  output  WIDTH  result; stable while out_valid=1.
- cout  output  1  carry out of the top nibble; stable while out_valid=1.
- fa_a  output  4  A nibble to the adder.
- fa_b  output  4  B nibble to the adder.
- fa_cin  output  1  carry to the adder.
- fa_sum  input  4  adder sum, combinational from fa_*.
- fa_cout  input  1  adder carry out.

Behaviour:
- Reset (rst=1 at a clk edge), from any state, including mid-operation:
  - state goes to IDLE.
  - in_ready=1 after reset.
  - out_valid=0, sum=0, cout=0.
  - step counter=0, carry register=0.
  - fa_a, fa_b and fa_cin driven 0.
  - Any in-flight operation is discarded with no partial result.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a, b and cin into the carry register, clear the step counter, go to RUN.
- RUN:
  - in_ready=0.
  - fa_a / fa_b = current low nibble of the A/B shift registers; fa_cin = carry register.
  - Each cycle: shift fa_sum into the result register from the top (result shifts right 4); shift A and B right 4; carry register <= fa_cout; counter++.
  - When the counter reaches NIB-1 in RUN, the final nibble is captured on that edge: cout <= fa_cout, go to DONE.
- DONE:
  - out_valid=1; sum and cout are held.
  - On out_ready=1, go to IDLE and drop out_valid.
  - in_ready stays 0 during DONE. No bypass: a new request is not accepted in the DONE→IDLE cycle.
  - Accept-to-out_valid latency is NIB+1 edges: 5 for WIDTH=16, 2 for WIDTH=4.
  - Issue-to-issue throughput is NIB+2 cycles minimum when out_ready is held high.
- Outside RUN, the fa_* outputs are driven 0.
- Arithmetic:
  - sum = (a + b + cin) mod 2^WIDTH.
  - cout = bit WIDTH of that sum.
  - No overflow or sign flag.
- Handshake rules:
  - in_valid may be asserted at any time; it is ignored unless in_ready=1.
  - Operands may change after accept without affecting the result.
  - out_valid, once high, stays high with sum/cout unchanged until out_ready=1.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes; the request waits for IDLE.

Optional Feature:
- Macro: NIBBLE_ADD_SUB_EN.
- When defined:
  - Extra input port sub (1 bit), sampled on accept.
  - With sub=1, the B shift register loads ~b and the carry register loads 1, ignoring cin. The result is a - b mod 2^WIDTH, and cout=1 means no borrow.
  - With sub=0, behaviour is identical to the undefined build.
- When undefined: no sub port; add-only.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> in_ready=1, out_valid=0, sum=0x0000, cout=0, fa_*=0.
- Basic add: a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid exactly 5 cycles after accept, sum=0x5555, cout=0.
- Full carry ripple across nibbles: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Also check fa_cin=1 in every RUN cycle.
- Backpressure: a=0x8000, b=0x8000, out_ready=0 for 6 cycles -> sum=0x0000, cout=1, stable while waiting; in_ready=0 throughout; returns to IDLE the cycle after out_ready=1.
- Reset mid-RUN: accept a=0x00FF, b=0x0001, assert rst on the 2nd RUN cycle -> IDLE, out_valid never rises. Next request a=0x0003, b=0x0004 -> sum=0x0007, carry not polluted.
- With NIBBLE_ADD_SUB_EN, sub=1:
  - a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0.
  - a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
